// File: rtl/sig_pkg.sv
// -----------------------------------------------------------------------------
// sig_pkg
// Shared definitions for the y-bus signature compressor.
//   state_e      : run-control states of the signature FSM
//   POLY8/16/32  : default feedback polynomials for common signature widths
//   fold_slices  : XOR-folds a zero-padded observation vector into one slice
// -----------------------------------------------------------------------------
package sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0]  POLY8  = 8'h1D;
    localparam logic [15:0] POLY16 = 16'h1021;
    localparam logic [31:0] POLY32 = 32'h04C11DB7;

    // Upper bounds for the generic fold helper. Callers zero-extend the
    // observation bus to FOLD_MAX_Y bits and keep the low sig_w result bits.
    localparam int FOLD_MAX_Y   = 2048;
    localparam int FOLD_MAX_SIG = 64;

    // Bit i of the (zero-padded) input lands in bit (i mod sig_w) of the
    // result, which is the XOR of all sig_w-wide slices with slice 0 at
    // the LSBs. Padding bits are zero, so they leave the result unchanged.
    function automatic logic [FOLD_MAX_SIG-1:0] fold_slices(
        input logic [FOLD_MAX_Y-1:0] y_pad,
        input int                    sig_w
    );
        logic [FOLD_MAX_SIG-1:0] r;
        r = '0;
        for (int i = 0; i < FOLD_MAX_Y; i++) begin
            r[6'(i % sig_w)] = r[6'(i % sig_w)] ^ y_pad[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/misr_step.sv
// -----------------------------------------------------------------------------
// misr_step
// Purely combinational next-signature computation: folds the observation
// bus into SIG_WIDTH bits and applies one shift/feedback step.
// Ports:
//   y        in  Y_WIDTH    observation bus
//   sig      in  SIG_WIDTH  current signature
//   sig_next out SIG_WIDTH  signature after absorbing y
// -----------------------------------------------------------------------------
module misr_step
    import sig_pkg::*;
#(
    parameter int                   Y_WIDTH   = 867,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(POLY32)
) (
    input  logic [Y_WIDTH-1:0]   y,
    input  logic [SIG_WIDTH-1:0] sig,
    output logic [SIG_WIDTH-1:0] sig_next
);

    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] shifted;

    assign fold = SIG_WIDTH'(fold_slices(FOLD_MAX_Y'(y), SIG_WIDTH));

    // Multiply by x modulo the feedback polynomial: shift left and, when the
    // MSB falls off, reduce by XORing in the polynomial.
    assign shifted = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0);

    assign sig_next = shifted ^ fold;

endmodule

// File: rtl/y_signature_misr.sv
// -----------------------------------------------------------------------------
// y_signature_misr
// Compresses the generated-top observation bus into a MISR signature over a
// programmable number of cycles. One-shot or continuous runs.
// Ports:
//   clk       in  1          rising-edge clock
//   rst       in  1          asynchronous active-high reset
//   start     in  1          begin a run (ignored while busy)
//   cont      in  1          continuous mode, captured with start
//   len       in  CNT_W      samples per run, captured with start
//   y         in  Y_WIDTH    observation bus
//   busy      out 1          high in RUN and DONE
//   sig       out SIG_WIDTH  running / final signature
//   sig_valid out 1          one-cycle pulse at run completion
//   run_cnt   out CNT_W      samples absorbed in the current run
// -----------------------------------------------------------------------------
module y_signature_misr
    import sig_pkg::*;
#(
    parameter int                   Y_WIDTH   = 867,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(POLY32),
    parameter logic [SIG_WIDTH-1:0] SEED      = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cont,
    input  logic [CNT_W-1:0]     len,
    input  logic [Y_WIDTH-1:0]   y,
    output logic                 busy,
    output logic [SIG_WIDTH-1:0] sig,
    output logic                 sig_valid,
    output logic [CNT_W-1:0]     run_cnt
);

    state_e               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic                 cont_q, cont_d;
    logic [SIG_WIDTH-1:0] sig_next;
    logic [CNT_W-1:0]     cnt_inc;

    misr_step #(
        .Y_WIDTH   (Y_WIDTH),
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .y        (y),
        .sig      (sig_q),
        .sig_next (sig_next)
    );

    assign cnt_inc = run_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        run_cnt_d = run_cnt_q;
        len_d     = len_q;
        cont_d    = cont_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    cont_d    = cont;
                    sig_d     = SEED;
                    run_cnt_d = '0;
                    state_d   = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // y is only consumed here, so X on y elsewhere is harmless.
                sig_d     = sig_next;
                run_cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cont_q) begin
                    // Restart with the captured length; a zero-length
                    // continuous run keeps pulsing from DONE every cycle
                    // rather than letting run_cnt wrap.
                    sig_d     = SEED;
                    run_cnt_d = '0;
                    state_d   = (len_q == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sig_q     <= SEED;
            run_cnt_q <= '0;
            len_q     <= '0;
            cont_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            run_cnt_q <= run_cnt_d;
            len_q     <= len_d;
            cont_q    <= cont_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign sig_valid = (state_q == DONE);
    assign sig       = sig_q;
    assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_y_signature_misr.sv
module tb_y_signature_misr;

    localparam int         YW = 16;
    localparam int         SW = 8;
    localparam int         CW = 16;
    localparam logic [7:0] P  = 8'h1D;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic [CW-1:0] len;
    logic [YW-1:0] y;

    logic          busy0, vld0, busy1, vld1;
    logic [SW-1:0] sig0, sig1;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_signature_misr #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .POLY(P), .SEED(8'h00), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .len(len), .y(y),
        .busy(busy0), .sig(sig0), .sig_valid(vld0), .run_cnt(cnt0));

    y_signature_misr #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .POLY(P), .SEED(8'h80), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .len(len), .y(y),
        .busy(busy1), .sig(sig1), .sig_valid(vld1), .run_cnt(cnt1));

    // Reference: signature arithmetic over GF(2) -- fold is the XOR of the
    // two bytes of y, a step multiplies by x modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] fold_ref(input logic [15:0] v);
        return v[15:8] ^ v[7:0];
    endfunction

    function automatic logic [7:0] step_ref(input logic [7:0] s, input logic [15:0] v);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ fold_ref(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sig0"}, 32'(sig0), 32'h00);
        chk({tag, "_sig1"}, 32'(sig1), 32'h80);
        chk({tag, "_busy"}, 32'({busy0, busy1}), 32'h0);
        chk({tag, "_vld"},  32'({vld0, vld1}), 32'h0);
        chk({tag, "_cnt"},  32'(cnt0), 32'h0);
    endtask

    // Asserts rst mid-cycle and checks the outputs before any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        start = 1'b0;
        tick();
        chk("rst_hold_vld", 32'({vld0, vld1}), 32'h0);
        rst = 1'b0;
        tick();
        chk_reset_vals("rst_release");
    endtask

    // One start followed by nruns complete runs of L samples each.
    // poke: random start/cont/len during busy (must be ignored).
    // abort_at: sample index at which rst is asserted (-1 for none).
    task automatic do_run(input int L, input bit c, input int nruns, input bit poke,
                          input bit fixed, input logic [15:0] fy, input int abort_at);
        logic [7:0] e0, e1;
        e0 = 8'h00;
        e1 = 8'h80;
        start = 1'b1;
        cont  = c;
        len   = 16'(L);
        y     = 'x;
        tick();
        start = 1'b0;
        cont  = 1'b0;
        len   = 16'($urandom);
        for (int r = 0; r < nruns; r++) begin
            e0 = 8'h00;
            e1 = 8'h80;
            for (int k = 0; k < L; k++) begin
                y = fixed ? fy : 16'($urandom);
                if (poke) begin
                    start = 1'($urandom_range(0, 1));
                    cont  = 1'($urandom_range(0, 1));
                    len   = 16'($urandom_range(0, 5));
                end
                if (k == abort_at) begin
                    async_reset();
                    return;
                end
                chk("run_busy", 32'({busy0, busy1}), 32'h3);
                chk("run_vld",  32'({vld0, vld1}), 32'h0);
                chk("run_cnt",  32'(cnt0), 32'(k));
                chk("run_sig0", 32'(sig0), 32'(e0));
                chk("run_sig1", 32'(sig1), 32'(e1));
                e0 = step_ref(e0, y);
                e1 = step_ref(e1, y);
                tick();
                start = 1'b0;
            end
            y = 'x;
            if (poke) start = 1'($urandom_range(0, 1));
            chk("done_vld",  32'({vld0, vld1}), 32'h3);
            chk("done_busy", 32'({busy0, busy1}), 32'h3);
            chk("done_cnt",  32'(cnt1), 32'(L));
            chk("done_sig0", 32'(sig0), 32'(e0));
            chk("done_sig1", 32'(sig1), 32'(e1));
            tick();
            start = 1'b0;
        end
        if (!c) begin
            chk("idle_busy", 32'({busy0, busy1}), 32'h0);
            chk("idle_vld",  32'({vld0, vld1}), 32'h0);
            chk("idle_sig0", 32'(sig0), 32'(e0));
            chk("idle_sig1", 32'(sig1), 32'(e1));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        len   = '0;
        y     = 'x;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        chk_reset_vals("post_reset");

        // Basic directed run: 03, 05, 09.
        do_run(3, 1'b0, 1, 1'b0, 1'b1, 16'h0102, -1);
        chk("basic_final", 32'(sig0), 32'h09);
        tick();
        chk("basic_idle_hold", 32'(sig0), 32'h09);

        // Feedback from MSB: seed 80, y=0, one sample.
        do_run(1, 1'b0, 1, 1'b0, 1'b1, 16'h0000, -1);
        chk("feedback_final", 32'(sig1), 32'h1D);

        // Zero length: straight to DONE with seed.
        do_run(0, 1'b0, 1, 1'b0, 1'b1, 16'h0000, -1);
        chk("zero_len_sig1", 32'(sig1), 32'h80);

        // Random one-shot runs with ignored start pulses while busy.
        for (int n = 0; n < 6; n++) begin
            do_run($urandom_range(1, 12), 1'b0, 1, 1'b1, 1'b0, 16'h0000, -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Continuous mode: period 3, sig 03 each time; start pokes ignored.
        do_run(2, 1'b1, 3, 1'b1, 1'b1, 16'h0001, -1);
        async_reset();

        // Random continuous runs, exited with reset.
        do_run($urandom_range(1, 6), 1'b1, 3, 1'b1, 1'b0, 16'h0000, -1);
        async_reset();

        // Reset mid-run at run_cnt=4, then an uninterrupted rerun.
        do_run(10, 1'b0, 1, 1'b0, 1'b1, 16'hA5C3, 4);
        do_run(10, 1'b0, 1, 1'b0, 1'b1, 16'hA5C3, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y_signature_misr.md
Name: y_signature_misr

Overview:
- Compresses a wide generated-design observation bus (`y`) into a fixed-width multiple-input signature register (MISR) over a programmable number of clock cycles.
- Used in differential tool testing: two netlists of the same generated top are compared by signature instead of cycle-by-cycle `y` dumps.
- Sits beside the generated `top`: `y` goes in, a signature and valid flag come out.
- Parametrised in observation width, signature width, polynomial, seed and run length; supports one-shot and continuous modes.

Parameters:
- Y_WIDTH, 867, width of the observed bus (matches the current generated-top `y` width).
- SIG_WIDTH, 32, signature width; must be at least 2.
- POLY, 32'h04C11DB7, feedback polynomial; low SIG_WIDTH bits are used.
- SEED, 0, signature value loaded at each run start.
- CNT_W, 16, width of the run-length counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run.
- cont  in  1  continuous mode; sampled with `start`.
- len  in  CNT_W  number of `y` samples to compress; sampled with `start`.
- y  in  Y_WIDTH  observation bus from the design under test.
- busy  out  1  high while compressing.
- sig  out  SIG_WIDTH  current or final signature.
- sig_valid  out  1  one-cycle pulse when a run completes.
- run_cnt  out  CNT_W  samples consumed in the current run.

Behaviour:
- Reset (asynchronous assert, release on clk): state=IDLE, sig=SEED, busy=0, sig_valid=0, run_cnt=0, latched cont/len cleared.
- Fold, combinational:
  - Zero-pad `y` up to a multiple of SIG_WIDTH.
  - fold = XOR of all SIG_WIDTH-bit slices; slice 0 is `y`[SIG_WIDTH-1:0].
- MISR step: sig_next = {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches `len` and `cont`, loads sig=SEED, clears run_cnt.
  - Goes to RUN if `len`≠0, else to DONE.
  - busy=1 from the cycle after `start`.
- RUN:
  - Each cycle: sig←sig_next, run_cnt←run_cnt+1.
  - When run_cnt+1 == latched `len`, go to DONE.
  - Exactly `len` samples are absorbed: the first is `y` in the cycle after `start`.
- DONE (one cycle):
  - sig_valid=1, sig holds the final value, busy stays 1 this cycle.
  - Next state is RUN if cont=1: sig reloads SEED, run_cnt clears, `len` is re-used.
  - Otherwise IDLE, busy=0.
- In IDLE, `sig` holds the last final signature until the next `start`.
- `start` while busy (RUN or DONE) is ignored; latched `len` and `cont` are not changed.
- To exit continuous mode, assert `rst`.
- run_cnt never wraps: its maximum is `len` ≤ 2^CNT_W−1.
- Reset mid-run: immediate abort to reset values; no sig_valid pulse.
- `y` is sampled only in RUN; X on `y` outside RUN has no effect.

Decomposition:
- Shared package `sig_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - Default POLY constants for 8/16/32-bit signatures (8'h1D, 16'h1021, 32'h04C11DB7).
  - A `fold_slices` function.
- One sub-module, `misr_step`: purely combinational fold plus shift/feedback, parametrised by Y_WIDTH, SIG_WIDTH and POLY.
- FSM and counter stay in the top module.

Test Plan (SIG_WIDTH=8, POLY=8'h1D, SEED=0, Y_WIDTH=16 unless stated):
- Reset check: assert rst asynchronously mid-cycle → sig=0, busy=0, sig_valid=0, run_cnt=0 immediately, without waiting for a clk edge.
- Basic run: `y`=16'h0102 (fold=8'h03), `start`, `len`=3 → sig 03, 05, 09; sig_valid pulses 4 cycles after `start` with sig=8'h09; busy falls the cycle after.
- Feedback: SEED=8'h80, `y`=0, `len`=1 → final sig=8'h1D.
- Zero length: `len`=0 → DONE the cycle after `start`, sig_valid=1 with sig=SEED, no samples absorbed.
- Continuous mode: `cont`=1, `len`=2, `y`=16'h0001 → sig_valid every 3 cycles with sig=8'h03 each time; `start` pulses during RUN are ignored.
- Reset mid-run: `len`=10, assert rst at run_cnt=4 → no sig_valid, sig=SEED; a fresh `start` after release gives the same signature as an uninterrupted run.
